instr_fetch_unit: RTL

Instruction fetch unit that supplies the 19-bit instruction word to the CPU core. It produces the PC stream, issues reads to a synchronous instruction memory, buffers returned words in a small prefetch FIFO, and hands each instruction plus its PC to the core with a valid/ready handshake. It sits between the instruction memory and the CPU `instruction` input, and replaces direct stimulus on that input.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifu_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/PC widths, instruction and PC types, opcode field location.
package cpu_pkg;

  localparam int unsigned INSTR_W = 19;
  localparam int unsigned PC_W    = 19;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [PC_W-1:0]    pc_t;

  localparam int unsigned OPC_MSB = 12;
  localparam int unsigned OPC_LSB = 9;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  function automatic logic [OPC_W-1:0] opcode_of(input instr_t i);
    return i[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO for the fetch unit: DEPTH entries (power of two), push/pop/flush, live count.
module ifu_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 38,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, one-cycle imem reads, prefetch FIFO, valid/ready to core.
// Optional `IFU_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned PC_W    = cpu_pkg::PC_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]         fpc;
  logic [PC_W-1:0]         tag;
  logic                    infl;
  logic [CW-1:0]           cnt;
  logic                    push;
  logic                    pop;
  logic [PC_W+INSTR_W-1:0] head;

  // Counting the in-flight read against capacity guarantees its push always finds room.
  assign imem_req  = reset && !redirect_valid && ((32'(cnt) + 32'(infl)) < DEPTH);
  assign imem_addr = fpc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc  <= '0;
      tag  <= '0;
      infl <= 1'b0;
    end else if (redirect_valid) begin
      fpc  <= redirect_pc;
      infl <= 1'b0;
    end else begin
      infl <= imem_req;
      if (imem_req) begin
        fpc <= fpc + PC_W'(1);
        tag <= fpc;
      end
    end
  end

  assign instr_valid = (cnt != '0);
  assign push        = infl && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  ifu_fifo #(
    .DATA_W (PC_W + INSTR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({tag, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (cnt)
  );

  assign {instr_pc, instr} = head;

`ifdef IFU_STALL_CNT_EN
  // The first edge after reset release is skipped: no fetch could have returned before it.
  logic run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run && instr_ready && !instr_valid && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
